// File: rtl/rf_arb_pkg.sv
// Shared constants and types for the two-port register-file arbiter and its storage.
package rf_arb_pkg;

  localparam int DW    = 8;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;

  typedef enum logic {PRIO_A = 1'b0, PRIO_B = 1'b1} prio_t;

  typedef logic [DW-1:0] word_t;

endpackage

// File: rtl/rf_1rw_core.sv
// Single-port flop-array register file with per-entry written flags.
// Reads are registered and return zero for entries never written since reset.
module rf_1rw_core #(
  parameter int DW = rf_arb_pkg::DW,
  parameter int AW = rf_arb_pkg::AW
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          en,
  input  logic          wr,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    mem_q [DEPTH];
  logic [DW-1:0]    mem_d [DEPTH];
  logic [DEPTH-1:0] written_q, written_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  // NOTE: every variable gets its default first so no path through the block leaves it unassigned (no latch).
  always_comb begin
    mem_d     = mem_q;
    written_d = written_q;
    rdata_d   = rdata_q;
    if (en) begin
      if (wr) begin
        mem_d[addr]     = wdata;
        written_d[addr] = 1'b1;
      end else begin
        rdata_d = written_q[addr] ? mem_q[addr] : '0;
      end
    end
  end

  // NOTE: the array is small and must read as zero after reset, so it is reset like any other flop.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      written_q <= '0;
      rdata_q   <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      mem_q     <= mem_d;
      written_q <= written_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/rf_arbiter_2p.sv
// Round-robin front end serialising two requesters onto one 1RW register file,
// with a registered read-return tag and a saturating contention counter.
module rf_arbiter_2p #(
  parameter int DW = rf_arb_pkg::DW,
  parameter int AW = rf_arb_pkg::AW,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_req,
  input  logic          a_wr,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_wdata,
  output logic          a_gnt,
  output logic          a_rvalid,
  output logic [DW-1:0] a_rdata,
  input  logic          b_req,
  input  logic          b_wr,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_wdata,
  output logic          b_gnt,
  output logic          b_rvalid,
  output logic [DW-1:0] b_rdata,
  output logic [CW-1:0] conflict_cnt
);

  import rf_arb_pkg::prio_t;
  import rf_arb_pkg::PRIO_A;
  import rf_arb_pkg::PRIO_B;

  prio_t         prio_q, prio_d;
  logic          rvalid_a_q, rvalid_a_d;
  logic          rvalid_b_q, rvalid_b_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic          core_en, core_wr;
  logic [AW-1:0] core_addr;
  logic [DW-1:0] core_wdata, core_rdata;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) prio_q <= PRIO_A;
    else         prio_q <= prio_d;
  end

  always_comb begin
    prio_d = prio_q;
    if (a_gnt)      prio_d = PRIO_B;
    else if (b_gnt) prio_d = PRIO_A;
  end

  always_comb begin
    a_gnt = a_req & (~b_req | (prio_q == PRIO_A));
    b_gnt = b_req & (~a_req | (prio_q == PRIO_B));
  end

  // Grants are mutually exclusive, so A's fields are chosen whenever A wins.
  assign core_en    = a_gnt | b_gnt;
  assign core_wr    = a_gnt ? a_wr    : b_wr;
  assign core_addr  = a_gnt ? a_addr  : b_addr;
  assign core_wdata = a_gnt ? a_wdata : b_wdata;

  rf_1rw_core #(.DW(DW), .AW(AW)) u_core (
    .clk    (clk),
    .resetn (resetn),
    .en     (core_en),
    .wr     (core_wr),
    .addr   (core_addr),
    .wdata  (core_wdata),
    .rdata  (core_rdata)
  );

  always_comb begin
    rvalid_a_d = a_gnt & ~a_wr;
    rvalid_b_d = b_gnt & ~b_wr;
    cnt_d      = cnt_q;
    if (a_req && b_req && (cnt_q != {CW{1'b1}})) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
      cnt_q      <= cnt_d;
    end
  end

  assign a_rvalid     = rvalid_a_q;
  assign b_rvalid     = rvalid_b_q;
  assign a_rdata      = rvalid_a_q ? core_rdata : '0;
  assign b_rdata      = rvalid_b_q ? core_rdata : '0;
  assign conflict_cnt = cnt_q;

endmodule
